// File: rtl/sort_host.sv
// Host-side controller for the 8-entry selection sorter: load a batch, start, read it back sorted.
// Optional sorter-wait timeout enabled by defining SORT_HOST_TIMEOUT_EN.
module sort_host #(
  parameter int unsigned DW      = 8,
  parameter int unsigned AW      = 3,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic [DW-1:0] srt_datain,
  output logic [AW-1:0] srt_addr,
  output logic          srt_wr,
  output logic          srt_start,
  input  logic [DW-1:0] srt_dataout,
  input  logic          srt_ready,
  output logic          busy,
  output logic          err
);

  typedef enum logic [2:0] {
    S_LOAD,
    S_START,
    S_WAIT_LO,
    S_WAIT_HI,
    S_RD_ADDR,
    S_RD_CAP,
    S_OUT
  } state_e;

  localparam logic [AW-1:0] K_LAST = {AW{1'b1}};

  state_e        state_q, state_d;
  logic [AW-1:0] k_q, k_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;

`ifdef SORT_HOST_TIMEOUT_EN
  localparam int unsigned CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  assign srt_datain = in_data;
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign busy       = (state_q != S_LOAD);

  // Next-state, sorter port and stream handshakes
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    out_data_d = out_data_q;
    in_ready   = 1'b0;
    srt_wr     = 1'b0;
    srt_start  = 1'b0;
    srt_addr   = addr_q;
    err        = 1'b0;
`ifdef SORT_HOST_TIMEOUT_EN
    cnt_d      = '0;
`endif

    case (state_q)
      S_LOAD: begin
        in_ready = srt_ready;
        srt_addr = k_q;
        if (in_valid && srt_ready) begin
          srt_wr = 1'b1;
          k_d    = k_q + AW'(1);
          if (k_q == K_LAST) state_d = S_START;
        end
      end
      S_START: begin
        if (srt_ready) begin
          srt_start = 1'b1;
          state_d   = S_WAIT_LO;
        end
      end
      // Wait for ready to fall first so a stale high ready is never taken as done
      S_WAIT_LO: if (!srt_ready) state_d = S_WAIT_HI;
      S_WAIT_HI: if (srt_ready) state_d = S_RD_ADDR;
      S_RD_ADDR: begin
        srt_addr = k_q;
        state_d  = S_RD_CAP;
      end
      S_RD_CAP: begin
        out_data_d = srt_dataout;
        state_d    = S_OUT;
      end
      S_OUT: begin
        if (out_ready) begin
          if (k_q == K_LAST) begin
            k_d     = '0;
            state_d = S_LOAD;
          end else begin
            k_d     = k_q + AW'(1);
            state_d = S_RD_ADDR;
          end
        end
      end
      default: begin
        k_d     = '0;
        state_d = S_LOAD;
      end
    endcase

`ifdef SORT_HOST_TIMEOUT_EN
    // Counter is zero on WAIT_LO entry and counts every cycle spent waiting
    if (state_q == S_WAIT_LO || state_q == S_WAIT_HI) begin
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CW'(TIMEOUT)) begin
        err     = 1'b1;
        k_d     = '0;
        state_d = S_LOAD;
      end
    end
`endif

    out_valid_d = (state_d == S_OUT);
    out_last_d  = (state_d == S_OUT) && (k_d == K_LAST);
    addr_d      = srt_addr;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= S_LOAD;
      k_q         <= '0;
      addr_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
`ifdef SORT_HOST_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      addr_q      <= addr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
`ifdef SORT_HOST_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_sort_host.sv
// Bench for sort_host: behavioural sorter stub plus a queue-sort reference for every batch.
module tb_sort_host;

  typedef logic [0:7][7:0] batch_t;

  logic       clk;
  logic       nrst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic [7:0] srt_datain;
  logic [2:0] srt_addr;
  logic       srt_wr;
  logic       srt_start;
  logic [7:0] srt_dataout;
  logic       srt_ready;
  logic       busy;
  logic       err;

  int vectors     = 0;
  int miscompares = 0;
  int start_cnt   = 0;
  int wr_cnt      = 0;
  int busy_left;
  bit drop_en     = 1'b0;
  bit hang_en     = 1'b0;
  batch_t mem;

  sort_host #(.DW(8), .AW(3), .TIMEOUT(20)) dut (
    .clk(clk), .nrst(nrst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .srt_datain(srt_datain), .srt_addr(srt_addr), .srt_wr(srt_wr), .srt_start(srt_start),
    .srt_dataout(srt_dataout), .srt_ready(srt_ready),
    .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic batch_t sort8(input batch_t a);
    logic [7:0] q[$];
    batch_t     r;
    q = {};
    for (int i = 0; i < 8; i++) q.push_back(a[i]);
    q.sort();
    for (int i = 0; i < 8; i++) r[i] = q[i];
    return r;
  endfunction

  // Sorter stub: sync write, 1-cycle read, ready low for a random time after start
  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      srt_ready   <= 1'b1;
      busy_left   <= 0;
      srt_dataout <= 8'h00;
    end else begin
      srt_dataout <= mem[srt_addr];
      if (srt_wr) mem[srt_addr] <= srt_datain;
      if (srt_start) begin
        busy_left <= hang_en ? 1000000 : int'($urandom_range(4, 12));
        srt_ready <= 1'b0;
      end else if (busy_left > 1) begin
        busy_left <= busy_left - 1;
      end else if (busy_left == 1) begin
        mem       <= sort8(mem);
        busy_left <= 0;
        srt_ready <= 1'b1;
      end else begin
        srt_ready <= !(drop_en && ($urandom_range(0, 3) == 0));
      end
    end
  end

  always @(posedge clk) begin
    if (srt_start) start_cnt <= start_cnt + 1;
    if (srt_wr)    wr_cnt    <= wr_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_out_data",  32'(out_data),  0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_last",  32'(out_last),  0);
    chk("rst_srt_wr",    32'(srt_wr),    0);
    chk("rst_srt_start", 32'(srt_start), 0);
    chk("rst_srt_addr",  32'(srt_addr),  0);
    chk("rst_busy",      32'(busy),      0);
    chk("rst_err",       32'(err),       0);
  endtask

  // Called at a negedge; returns at the negedge after the byte's handshake edge
  task automatic push_byte(input logic [7:0] b);
    int g = 0;
    in_data  = b;
    in_valid = 1'b1;
    #1;
    while (!in_ready && g < 200) begin
      @(negedge clk);
      #1;
      g++;
    end
    chk("in_handshake_bound", 32'(g < 200), 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic read_batch(input batch_t e, input int sw, input int sl);
    int g;
    for (int j = 0; j < 8; j++) begin
      out_ready = !(j == sw && sl > 0);
      in_valid  = 1'b1;
      in_data   = 8'($urandom);
      g = 0;
      while (!out_valid && g < 300) begin
        @(negedge clk);
        g++;
      end
      chk("out_valid_bound", 32'(g < 300), 1);
      chk("in_ready_blocked", 32'(in_ready), 0);
      if (j == sw) begin
        for (int s = 0; s < sl; s++) begin
          @(negedge clk);
          chk("stall_valid", 32'(out_valid), 1);
          chk("stall_data", 32'(out_data), 32'(e[j]));
        end
        out_ready = 1'b1;
      end
      chk("out_data", 32'(out_data), 32'(e[j]));
      chk("out_last", 32'(out_last), 32'(j == 7));
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic run_batch(input batch_t b, input int sw, input int sl);
    int s0;
    int w0;
    s0 = start_cnt;
    w0 = wr_cnt;
    chk("busy_idle", 32'(busy), 0);
    for (int i = 0; i < 8; i++) push_byte(b[i]);
    chk("busy_after_load", 32'(busy), 1);
    chk("write_count", 32'(wr_cnt - w0), 8);
    read_batch(sort8(b), sw, sl);
    chk("start_pulses", 32'(start_cnt - s0), 1);
    chk("busy_done", 32'(busy), 0);
    chk("err_quiet", 32'(err), 0);
  endtask

  initial begin
    batch_t b;
    int     g;
    bit     early;
    nrst      = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_vals();
    nrst = 1'b1;
    @(negedge clk);

    b = '{8'd5, 8'd3, 8'd7, 8'd1, 8'd0, 8'd255, 8'd2, 8'd4};
    run_batch(b, 8, 0);
    b = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
    run_batch(b, 8, 0);
    b = '{8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
    run_batch(b, 8, 0);
    b = '{8'd9, 8'd9, 8'd1, 8'd9, 8'd1, 8'd1, 8'd9, 8'd1};
    run_batch(b, 8, 0);
    b = '{8'd40, 8'd10, 8'd30, 8'd20, 8'd80, 8'd60, 8'd70, 8'd50};
    run_batch(b, 3, 5);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 8; i++) b[i] = 8'($urandom);
      drop_en = r[0];
      run_batch(b, int'($urandom_range(0, 7)), int'($urandom_range(0, 4)));
    end
    drop_en = 1'b0;

    // Abort a batch while the host waits in WAIT_HI, then run a fresh one
    b = '{8'd11, 8'd22, 8'd33, 8'd44, 8'd55, 8'd66, 8'd77, 8'd88};
    for (int i = 0; i < 8; i++) push_byte(b[i]);
    g = 0;
    while (srt_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk("abort_wait_bound", 32'(g < 50), 1);
    @(negedge clk);
    chk("abort_busy", 32'(busy), 1);
    nrst = 1'b0;
    #1;
    chk_reset_vals();
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    b = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    run_batch(b, 8, 0);

`ifdef SORT_HOST_TIMEOUT_EN
    hang_en = 1'b1;
    b = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    for (int i = 0; i < 8; i++) push_byte(b[i]);
    @(negedge clk);
    early = 1'b0;
    for (int i = 0; i < 20; i++) begin
      early |= err;
      @(negedge clk);
    end
    chk("timeout_early", 32'(early), 0);
    chk("timeout_err", 32'(err), 1);
    @(negedge clk);
    chk("timeout_busy", 32'(busy), 0);
    chk("timeout_pulse", 32'(err), 0);
    hang_en = 1'b0;
    nrst = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
`else
    early = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
